// File: rtl/vop2_pkg.sv
// rtl/vop2_pkg.sv - shared VOP2 field layout, opcodes, FSM states and bundle type
package vop2_pkg;

  localparam int OP_LSB    = 25;
  localparam int OP_W      = 6;
  localparam int VDST_LSB  = 17;
  localparam int VDST_W    = 8;
  localparam int VSRC1_LSB = 9;
  localparam int VSRC1_W   = 8;
  localparam int SRC0_LSB  = 0;
  localparam int SRC0_W    = 9;

  localparam logic [SRC0_W-1:0] LIT_SRC = 9'd255;

  typedef enum logic [OP_W-1:0] {
    V_CNDMASK_B32 = 6'd0,
    V_ADD_F32     = 6'd3,
    V_SUB_F32     = 6'd4,
    V_MUL_F32     = 6'd8,
    V_FMAC_F32    = 6'd43,
    V_FMAMK_F32   = 6'd44,
    V_FMAAK_F32   = 6'd45
  } vop2_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LIT  = 1'b1
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [VDST_W-1:0]  vdst;
    logic [VSRC1_W-1:0] vsrc1;
    logic [SRC0_W-1:0]  src0;
  } vop2_fields_t;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [VDST_W-1:0]  vdst;
    logic [VSRC1_W-1:0] vsrc1;
    logic [SRC0_W-1:0]  src0;
    logic               has_lit;
    logic [31:0]        literal;
  } vop2_bundle_t;

  function automatic vop2_bundle_t make_bundle(input vop2_fields_t f,
                                               input logic has_lit,
                                               input logic [31:0] literal);
    vop2_bundle_t b;
    b.op      = f.op;
    b.vdst    = f.vdst;
    b.vsrc1   = f.vsrc1;
    b.src0    = f.src0;
    b.has_lit = has_lit;
    b.literal = literal;
    return b;
  endfunction

endpackage

// File: rtl/vop2_issue_if.sv
// rtl/vop2_issue_if.sv - instruction dword input and decoded bundle output handshakes
interface vop2_issue_if;
  import vop2_pkg::*;

  logic               in_valid;
  logic [31:0]        in_dword;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [OP_W-1:0]    out_op;
  logic [VDST_W-1:0]  out_vdst;
  logic [VSRC1_W-1:0] out_vsrc1;
  logic [SRC0_W-1:0]  out_src0;
  logic               out_has_lit;
  logic [31:0]        out_literal;

  // master: instruction buffer + ALU side; slave: the issue block
  modport master (
    output in_valid, in_dword, out_ready,
    input  in_ready, out_valid, out_op, out_vdst, out_vsrc1, out_src0,
           out_has_lit, out_literal
  );

  modport slave (
    input  in_valid, in_dword, out_ready,
    output in_ready, out_valid, out_op, out_vdst, out_vsrc1, out_src0,
           out_has_lit, out_literal
  );

endinterface

// File: rtl/vop2_field_decode.sv
// rtl/vop2_field_decode.sv - combinational VOP2 dword splitter with legality and literal flags
module vop2_field_decode #(
  parameter logic [8:0] LIT_SRC  = vop2_pkg::LIT_SRC,
  parameter logic [5:0] OP_FMAMK = vop2_pkg::V_FMAMK_F32,
  parameter logic [5:0] OP_FMAAK = vop2_pkg::V_FMAAK_F32
) (
  input  logic [31:0]           dword,
  output vop2_pkg::vop2_fields_t fields,
  output logic                  is_vop2,
  output logic                  needs_literal
);
  import vop2_pkg::*;

  always_comb begin
    fields.op    = dword[OP_LSB    +: OP_W];
    fields.vdst  = dword[VDST_LSB  +: VDST_W];
    fields.vsrc1 = dword[VSRC1_LSB +: VSRC1_W];
    fields.src0  = dword[SRC0_LSB  +: SRC0_W];
  end

  assign is_vop2       = ~dword[31];
  assign needs_literal = (fields.src0 == LIT_SRC) ||
                         (fields.op == OP_FMAMK) || (fields.op == OP_FMAAK);

endmodule

// File: rtl/vop2_issue.sv
// rtl/vop2_issue.sv - VOP2 issue front end: decode, literal collection, single-entry output register
module vop2_issue #(
  parameter int         CNT_W    = 16,
  parameter logic [8:0] LIT_SRC  = vop2_pkg::LIT_SRC,
  parameter logic [5:0] OP_FMAMK = vop2_pkg::V_FMAMK_F32,
  parameter logic [5:0] OP_FMAAK = vop2_pkg::V_FMAAK_F32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  vop2_issue_if.slave      bus,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);
  import vop2_pkg::*;

  state_e       state, state_n;
  vop2_fields_t fields, hold, hold_n;
  vop2_bundle_t bundle, bundle_n;
  logic         out_valid, valid_n, illegal_n;
  logic         is_vop2, needs_literal;
  logic         in_ready, acc, take;

  vop2_field_decode #(
    .LIT_SRC  (LIT_SRC),
    .OP_FMAMK (OP_FMAMK),
    .OP_FMAAK (OP_FMAAK)
  ) u_decode (
    .dword         (bus.in_dword),
    .fields        (fields),
    .is_vop2       (is_vop2),
    .needs_literal (needs_literal)
  );

  // No skid buffer: a new dword is only taken when the output slot frees this cycle.
  assign in_ready = !flush && (!out_valid || bus.out_ready);
  assign acc      = bus.in_valid && in_ready;
  assign take     = out_valid && bus.out_ready;

  always_comb begin
    state_n   = state;
    hold_n    = hold;
    bundle_n  = bundle;
    valid_n   = out_valid && !take;
    illegal_n = 1'b0;
    if (flush) begin
      state_n = S_IDLE;
      hold_n  = '0;
      valid_n = 1'b0;
    end else if (acc) begin
      unique case (state)
        S_IDLE: begin
          if (!is_vop2) begin
            illegal_n = 1'b1;
          end else if (needs_literal) begin
            hold_n  = fields;
            state_n = S_LIT;
          end else begin
            bundle_n = make_bundle(fields, 1'b0, 32'd0);
            valid_n  = 1'b1;
          end
        end
        S_LIT: begin
          // Literal dword is raw data, so bit31 is not a legality marker here.
          bundle_n = make_bundle(hold, 1'b1, bus.in_dword);
          valid_n  = 1'b1;
          state_n  = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold      <= '0;
      bundle    <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      bundle    <= bundle_n;
      out_valid <= valid_n;
      illegal   <= illegal_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count <= '0;
    end else if (take) begin
      issue_count <= issue_count + CNT_W'(1);
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_op      = bundle.op;
  assign bus.out_vdst    = bundle.vdst;
  assign bus.out_vsrc1   = bundle.vsrc1;
  assign bus.out_src0    = bundle.src0;
  assign bus.out_has_lit = bundle.has_lit;
  assign bus.out_literal = bundle.literal;

endmodule

// File: tb/tb_vop2_issue.sv
// tb/tb_vop2_issue.sv - randomized scoreboard bench for vop2_issue
module tb_vop2_issue;
  import vop2_pkg::*;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             illegal;
  logic [CNT_W-1:0] issue_count;

  vop2_issue_if bus();

  vop2_issue #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .illegal     (illegal),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  vop2_bundle_t exp_q[$];

  // Reference model state: an instruction either waits for its literal or sits in the output slot.
  logic        m_valid;
  logic        m_wait_lit;
  logic [31:0] m_first;
  logic        m_illegal;
  int          m_count;

  logic             cur_valid;
  logic             cur_in_ready;
  logic             cur_illegal;
  logic [CNT_W-1:0] cur_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vop2_bundle_t expect_bundle(input logic [31:0] first, input logic lit,
                                                 input logic [31:0] literal);
    vop2_bundle_t b;
    b.op      = first[30:25];
    b.vdst    = first[24:17];
    b.vsrc1   = first[16:9];
    b.src0    = first[8:0];
    b.has_lit = lit;
    b.literal = lit ? literal : 32'd0;
    return b;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_valid    = 1'b0;
    m_wait_lit = 1'b0;
    m_first    = '0;
    m_illegal  = 1'b0;
    m_count    = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic acc, take, nxt_valid;
    @(posedge clk);
    #2;
    rst_n         = 1'b1;
    bus.in_valid  = v;
    bus.in_dword  = d;
    bus.out_ready = r;
    flush         = f;

    cur_valid    = m_valid;
    cur_in_ready = !f && (!m_valid || r);
    cur_illegal  = m_illegal;
    cur_count    = CNT_W'(m_count);

    acc  = v && cur_in_ready;
    take = m_valid && r;
    if (take) m_count++;
    m_illegal = 1'b0;
    if (f) begin
      if (m_valid && !r) void'(exp_q.pop_front());
      m_valid    = 1'b0;
      m_wait_lit = 1'b0;
    end else begin
      nxt_valid = m_valid && !take;
      if (acc) begin
        if (m_wait_lit) begin
          exp_q.push_back(expect_bundle(m_first, 1'b1, d));
          nxt_valid  = 1'b1;
          m_wait_lit = 1'b0;
        end else if (d[31]) begin
          m_illegal = 1'b1;
        end else if (d[8:0] == 9'd255 || d[30:25] == 6'd44 || d[30:25] == 6'd45) begin
          m_first    = d;
          m_wait_lit = 1'b1;
        end else begin
          exp_q.push_back(expect_bundle(d, 1'b0, 32'd0));
          nxt_valid = 1'b1;
        end
      end
      m_valid = nxt_valid;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    model_reset();
    cur_valid    = 1'b0;
    cur_in_ready = 1'b1;
    cur_illegal  = 1'b0;
    cur_count    = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  // Monitor: compares per-cycle status and pops the scoreboard on every output handshake.
  initial begin
    vop2_bundle_t act, exp;
    forever begin
      @(negedge clk);
      check("in_ready", bus.in_ready, cur_in_ready);
      check("out_valid", bus.out_valid, cur_valid);
      check("illegal", illegal, cur_illegal);
      check("issue_count", issue_count, cur_count);
      if (bus.out_valid && bus.out_ready) begin
        act.op      = bus.out_op;
        act.vdst    = bus.out_vdst;
        act.vsrc1   = bus.out_vsrc1;
        act.src0    = bus.out_src0;
        act.has_lit = bus.out_has_lit;
        act.literal = bus.out_literal;
        if (exp_q.size() == 0) begin
          check("unexpected_bundle", act, 64'd0 - 64'd1);
        end else begin
          exp = exp_q.pop_front();
          check("bundle", act, exp);
        end
      end
    end
  end

  initial begin
    logic        v, r, f;
    logic [31:0] d;
    int          k;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_dword  = '0;
    bus.out_ready = 1'b1;
    model_reset();
    cur_valid    = 1'b0;
    cur_in_ready = 1'b1;
    cur_illegal  = 1'b0;
    cur_count    = '0;
    idle(2);

    step(1'b1, 32'h0602_0501, 1'b1, 1'b0);
    step(1'b1, 32'h0804_0702, 1'b1, 1'b0);
    idle(2);

    step(1'b1, 32'h0402_02FF, 1'b1, 1'b0);
    step(1'b1, 32'h3F80_0000, 1'b1, 1'b0);
    idle(2);

    step(1'b1, 32'h5802_0401, 1'b1, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    idle(2);

    step(1'b1, 32'h0602_0501, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0804_0702, 1'b0, 1'b0);
    step(1'b1, 32'h0804_0702, 1'b1, 1'b0);
    idle(2);

    step(1'b1, 32'hBE80_0000, 1'b1, 1'b0);
    idle(2);

    step(1'b1, 32'h0402_02FF, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'h0602_0501, 1'b1, 1'b0);
    idle(2);

    step(1'b1, 32'h0402_02FF, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 32'h0602_0501, 1'b1, 1'b0);
    idle(2);

    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0A06_0903, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    check("wrap_count", issue_count, 64'd1);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      v = ($urandom_range(0, 3) != 0);
      d = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0) d[31] = 1'b1;
      else d[31] = 1'b0;
      if (k == 1 || k == 2) d[8:0] = 9'd255;
      if (k == 3) d[30:25] = $urandom_range(0, 1) ? 6'd44 : 6'd45;
      r = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 49) == 0);
      step(v, d, r, f);
    end

    idle(4);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vop2_issue.md
Name: vop2_issue

Overview:
- Issue-side front end for the VOP2 vector ALU.
- Accepts a stream of 32-bit instruction dwords from the instruction buffer and decodes VOP2 encodings.
- Collects the optional trailing 32-bit literal, then presents one decoded, registered instruction bundle to the ALU over a valid/ready handshake.
- Rejects non-VOP2 dwords and counts issued instructions.

Parameters:
- CNT_W, 16, width of the issued-instruction counter.
- LIT_SRC, 9'd255, src0 encoding that means a literal dword follows.
- OP_FMAMK, 6'd44, VOP2 opcode that always carries a literal.
- OP_FMAAK, 6'd45, VOP2 opcode that always carries a literal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; drops any partial or held instruction.
- in_valid  in  1  in_dword is valid.
- in_dword  in  32  instruction dword from the instruction buffer.
- in_ready  out  1  dword accepted when in_valid && in_ready.
- out_valid  out  1  decoded bundle valid toward the ALU.
- out_ready  in  1  ALU accepts bundle when out_valid && out_ready.
- out_op  out  6  VOP2 opcode, in_dword[30:25].
- out_vdst  out  8  destination VGPR, [24:17].
- out_vsrc1  out  8  VGPR source 1, [16:9].
- out_src0  out  9  source 0 operand code, [8:0].
- out_has_lit  out  1  out_literal is meaningful.
- out_literal  out  32  literal dword; 0 when out_has_lit=0.
- illegal  out  1  one-cycle pulse: a dword with bit31=1 was dropped.
- issue_count  out  CNT_W  number of completed out handshakes, wraps.

Behaviour:
- Reset (rst_n=0, async) sets:
  - state=S_IDLE;
  - out_valid=0, all out_* fields=0, out_has_lit=0;
  - illegal=0, issue_count=0;
  - hold registers=0.
- Legend: acc = in_valid && in_ready; take = out_valid && out_ready.
- in_ready = !flush && (!out_valid || out_ready), in every state. The output register is single-entry with no skid buffer.
- A literal is required when src0==LIT_SRC, or op==OP_FMAMK, or op==OP_FMAAK.
- FSM states: S_IDLE, S_LIT.
- S_IDLE, on acc:
  - dword[31]=1: illegal=1 next cycle; dword dropped; output unchanged except drain by take; stay in S_IDLE.
  - VOP2, no literal: load output fields with out_has_lit=0 and out_literal=0; out_valid=1 next cycle; stay in S_IDLE.
  - VOP2, literal required: capture op/vdst/vsrc1/src0 into hold registers; go to S_LIT. out_valid is unaffected, apart from clearing on take.
- S_LIT, on acc: the dword is the literal, with no legality check on bit31. Load output from hold + literal with out_has_lit=1; out_valid=1 next cycle; go to S_IDLE.
- Latency: 1 cycle from acceptance of the final dword of an instruction to out_valid.
- Throughput:
  - Non-literal instructions issue back-to-back at 1 per cycle while out_ready=1.
  - Literal instructions take 2 input cycles each.
- While out_valid=1 and out_ready=0, all out_* fields hold stable and in_ready=0.
- Simultaneous take and acc in the same cycle: the output register is replaced by the new instruction; out_valid stays 1.
- take without a new load: out_valid=0 next cycle.
- issue_count increments by 1 on every take, wrapping from 2^CNT_W-1 to 0.
- flush=1, with priority over all other events in that cycle:
  - next cycle out_valid=0 and state=S_IDLE;
  - hold registers are cleared;
  - illegal=0;
  - issue_count is unaffected, and a take coinciding with flush still counts.
- illegal is registered and asserts only for the cycle after the offending acc.
- Reset mid-literal returns the block to S_IDLE; the captured partial instruction is lost.

Decomposition:
- Shared package vop2_pkg:
  - VOP2 field offsets and widths;
  - the opcode enum, including V_FMAMK_F32=44 and V_FMAAK_F32=45;
  - the LIT_SRC constant;
  - a vop2_bundle_t struct (op, vdst, vsrc1, src0, has_lit, literal).
- The VOP2 ALU consumes vop2_bundle_t from this package.
- The FSM, hold registers and counter stay in one module.
- One natural sub-module: vop2_field_decode, a combinational dword-to-fields splitter plus the needs_literal and is_vop2 flags.

Test Plan:
- Reset then idle: out_valid=0, issue_count=0, in_ready=1.
- Non-literal, back-to-back issue:
  - stimulus: out_ready=1; dword 0x0602_0501 (op=3, vdst=1, vsrc1=2, src0=0x101); then 0x0804_0702.
  - response: bundles appear on consecutive cycles with 1-cycle latency; out_has_lit=0; issue_count=2.
- Literal via src0: dwords 0x0402_02FF then 0x3F80_0000 -> single bundle with op=2, src0=255, out_has_lit=1, out_literal=0x3F80_0000; in S_LIT in_ready remains 1.
- Implicit literal via FMAMK:
  - stimulus: dword 0x5802_0401 (op=44), then 0xDEAD_BEEF.
  - response: out_has_lit=1 and out_literal=0xDEAD_BEEF; the bit31=1 literal does not pulse illegal.
- Backpressure, illegal and wrap:
  - stimulus: out_ready=0 while a bundle is held.
  - response: in_ready=0 and fields stable for 5 cycles.
  - stimulus: dword 0xBE80_0000.
  - response: illegal pulses exactly 1 cycle with no bundle.
  - stimulus: CNT_W=2 with 5 takes.
  - response: issue_count=1.
- Flush and reset in S_LIT:
  - stimulus: flush asserted while in S_LIT after 0x0402_02FF.
  - response: next cycle out_valid=0 and state returns to S_IDLE; the next dword 0x0602_0501 decodes as a fresh instruction.
  - stimulus: rst_n pulsed in S_LIT.
  - response: same recovery.
